// File: rtl/bitcoin_pkg.sv
// Shared types and helpers for the share checker: digest/hash types,
// byte swap, and compact nBits -> 256-bit target expansion.
package bitcoin_pkg;

   localparam int unsigned WORD_W        = 32;
   localparam int unsigned HASH_W        = 256;
   localparam int unsigned NONCE_W       = 32;
   localparam int unsigned ENTRY_W       = NONCE_W + HASH_W;
   localparam int unsigned BITS_SIGN_BIT = 23;
   localparam int unsigned MAX_EXP       = 32;

   typedef logic [7:0][WORD_W-1:0] digest_t;
   typedef logic [HASH_W-1:0]      hash256_t;

   typedef struct packed {
      logic     ok;
      hash256_t target;
   } target_t;

   typedef struct packed {
      logic [NONCE_W-1:0] nonce;
      hash256_t           hash;
   } entry_t;

   // Reverse the four bytes of a 32-bit word (htonl).
   function automatic logic [WORD_W-1:0] bswap32(input logic [WORD_W-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

   // Bitcoin hash integer: H7 byte-swapped lands in the most significant word.
   function automatic hash256_t digest_to_hash(input digest_t d);
      hash256_t h;
      for (int i = 0; i < 8; i++) begin
         h[WORD_W*i +: WORD_W] = bswap32(d[i]);
      end
      return h;
   endfunction

   // Expand compact nBits; negative, zero-mantissa or oversized exponents are invalid.
   function automatic target_t compact_to_target(input logic [31:0] bits);
      target_t    r;
      logic [7:0] e;
      logic [7:0] sh;
      hash256_t   m;
      e        = bits[31:24];
      m        = HASH_W'(bits[22:0]);
      r.ok     = 1'b0;
      r.target = '0;
      if (bits[BITS_SIGN_BIT] || (bits[22:0] == 23'd0) || (e > 8'(MAX_EXP))) begin
         r.ok     = 1'b0;
         r.target = '0;
      end else if (e <= 8'd3) begin
         sh       = 8'((8'd3 - e) << 3);
         r.ok     = 1'b1;
         r.target = m >> sh;
      end else begin
         sh       = 8'((e - 8'd3) << 3);
         r.ok     = 1'b1;
         r.target = m << sh;
      end
      return r;
   endfunction

endpackage

// File: rtl/bitcoin_found_fifo.sv
// Small synchronous FIFO with a registered head entry; no push->pop bypass.
module bitcoin_found_fifo
   import bitcoin_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = ENTRY_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] head_q, head_d;
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full_q, full_d, empty_q, empty_d;
   logic             pop_ok, push_ok;

   assign pop_ok  = pop_i & ~empty_q;
   assign push_ok = push_i & (~full_q | pop_ok);

   // Next pointers, occupancy and head entry.
   always_comb begin
      rd_d    = rd_q;
      wr_d    = wr_q;
      head_d  = head_q;
      cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      if (pop_ok) begin
         if (cnt_q > CW'(1))  head_d = mem_q[rd_d];
         else if (push_ok)    head_d = push_data_i;
      end else if (empty_q && push_ok) begin
         head_d = push_data_i;
      end
      full_d  = (cnt_d == CW'(DEPTH));
      empty_d = (cnt_d == CW'(0));
   end

   // Control and head registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= push_data_i;
   end

   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign head_o  = head_q;

endmodule

// File: rtl/bitcoin_share_checker.sv
// Converts miner digests to hash integers, compares against the nBits target,
// queues winning nonces for the host and keeps throughput counters.
module bitcoin_share_checker
   import bitcoin_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 48,
   parameter int unsigned DROP_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_load,
   input  logic [31:0]          cfg_bits,
   input  logic                 in_valid,
   input  logic [7:0][31:0]     in_digest,
   input  logic [31:0]          in_nonce,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_nonce,
   output logic [255:0]         out_hash,
   output logic [CNT_W-1:0]     hash_cnt,
   output logic [15:0]          found_cnt,
   output logic [DROP_W-1:0]    drop_cnt,
   output logic                 target_ok
);

   hash256_t            target_q;
   logic                target_ok_q;
   logic                s1_valid_q;
   hash256_t            s1_hash_q;
   logic [NONCE_W-1:0]  s1_nonce_q;
   logic                s2_meet_q, s2_meet_d;
   hash256_t            s2_hash_q;
   logic [NONCE_W-1:0]  s2_nonce_q;
   logic [CNT_W-1:0]    hash_cnt_q;
   logic [15:0]         found_cnt_q;
   logic [DROP_W-1:0]   drop_cnt_q;
   logic                fifo_full, fifo_empty, pop_c, push_ok_c, drop_c;
   entry_t              head;

   // Latch and expand the compact target on cfg_load.
   always_ff @(posedge clk) begin
      if (rst) begin
         target_q    <= '0;
         target_ok_q <= 1'b0;
      end else if (cfg_load) begin
         {target_ok_q, target_q} <= compact_to_target(cfg_bits);
      end
   end

   // Stage 1: byte-swap digest into the hash integer and count samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_hash_q  <= '0;
         s1_nonce_q <= '0;
         hash_cnt_q <= '0;
      end else begin
         s1_valid_q <= in_valid;
         hash_cnt_q <= hash_cnt_q + CNT_W'(in_valid);
         if (in_valid) begin
            s1_hash_q  <= digest_to_hash(in_digest);
            s1_nonce_q <= in_nonce;
         end
      end
   end

   assign s2_meet_d = s1_valid_q & target_ok_q & (s1_hash_q <= target_q);

   // Stage 2: register the target comparison with its payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_meet_q  <= 1'b0;
         s2_hash_q  <= '0;
         s2_nonce_q <= '0;
      end else begin
         s2_meet_q  <= s2_meet_d;
         s2_hash_q  <= s1_hash_q;
         s2_nonce_q <= s1_nonce_q;
      end
   end

   assign pop_c     = ~fifo_empty & out_ready;
   assign push_ok_c = s2_meet_q & (~fifo_full | pop_c);
   assign drop_c    = s2_meet_q & fifo_full & ~pop_c;

   bitcoin_found_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (s2_meet_q),
      .push_data_i ({s2_nonce_q, s2_hash_q}),
      .pop_i       (pop_c),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head)
   );

   // Saturating share and drop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         found_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (push_ok_c && (found_cnt_q != '1)) found_cnt_q <= found_cnt_q + 16'(1);
         if (drop_c && (drop_cnt_q != '1))     drop_cnt_q  <= drop_cnt_q + DROP_W'(1);
      end
   end

   assign out_valid = ~fifo_empty;
   assign out_nonce = head.nonce;
   assign out_hash  = head.hash;
   assign hash_cnt  = hash_cnt_q;
   assign found_cnt = found_cnt_q;
   assign drop_cnt  = drop_cnt_q;
   assign target_ok = target_ok_q;

endmodule

// File: tb/tb_bitcoin_share_checker.sv
// Directed self-checking bench for bitcoin_share_checker.
module tb_bitcoin_share_checker;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_load;
   logic [31:0]     cfg_bits;
   logic            in_valid;
   logic [7:0][31:0] in_digest;
   logic [31:0]     in_nonce;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_nonce;
   logic [255:0]    out_hash;
   logic [47:0]     hash_cnt;
   logic [15:0]     found_cnt;
   logic [15:0]     drop_cnt;
   logic            target_ok;

   int total = 0;
   int bad   = 0;

   localparam logic [255:0] GEN_HASH =
      256'h0000000000000000e067a478024addfecdc93628978aa52d91fabd4292982a50;

   bitcoin_share_checker #(.FIFO_DEPTH(4), .CNT_W(48), .DROP_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_load  (cfg_load),
      .cfg_bits  (cfg_bits),
      .in_valid  (in_valid),
      .in_digest (in_digest),
      .in_nonce  (in_nonce),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_nonce (out_nonce),
      .out_hash  (out_hash),
      .hash_cnt  (hash_cnt),
      .found_cnt (found_cnt),
      .drop_cnt  (drop_cnt),
      .target_ok (target_ok)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cfg_bits = '0; in_digest = '0; in_nonce = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic load_cfg(input logic [31:0] bits);
      cfg_load = 1'b1; cfg_bits = bits;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic set_genesis(input logic [31:0] nonce);
      in_digest[7] = 32'h00000000; in_digest[6] = 32'h00000000;
      in_digest[5] = 32'h78a467e0; in_digest[4] = 32'hfedd4a02;
      in_digest[3] = 32'h2836c9cd; in_digest[2] = 32'h2da58a97;
      in_digest[1] = 32'h42bdfa91; in_digest[0] = 32'h502a9892;
      in_nonce = nonce;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
      total++; if (out_nonce !== 32'h0) begin bad++; $display("FAIL reset_out_nonce got=%h want=0", out_nonce); end
      total++; if (out_hash !== 256'h0) begin bad++; $display("FAIL reset_out_hash got=%h want=0", out_hash); end
      total++; if (hash_cnt !== 48'h0) begin bad++; $display("FAIL reset_hash_cnt got=%0d want=0", hash_cnt); end
      total++; if (found_cnt !== 16'h0) begin bad++; $display("FAIL reset_found_cnt got=%0d want=0", found_cnt); end
      total++; if (drop_cnt !== 16'h0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
      total++; if (target_ok !== 1'b0) begin bad++; $display("FAIL reset_target_ok got=%0b want=0", target_ok); end
   endtask

   task automatic test_genesis();
      do_reset();
      load_cfg(32'h19015f53);
      total++; if (target_ok !== 1'b1) begin bad++; $display("FAIL gen_target_ok got=%0b want=1", target_ok); end
      set_genesis(32'h33087548); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gen_early_valid got=%0b want=0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gen_valid_t3 got=%0b want=1", out_valid); end
      total++; if (out_nonce !== 32'h33087548) begin bad++; $display("FAIL gen_nonce got=%h want=33087548", out_nonce); end
      total++; if (out_hash !== GEN_HASH) begin bad++; $display("FAIL gen_hash got=%h want=%h", out_hash, GEN_HASH); end
      total++; if (found_cnt !== 16'd1) begin bad++; $display("FAIL gen_found_cnt got=%0d want=1", found_cnt); end
      total++; if (hash_cnt !== 48'd1) begin bad++; $display("FAIL gen_hash_cnt got=%0d want=1", hash_cnt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gen_pop_empty got=%0b want=0", out_valid); end
   endtask

   task automatic test_tighter();
      do_reset();
      load_cfg(32'h1700ffff);
      set_genesis(32'h33087548); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL tight_out_valid got=%0b want=0", out_valid); end
      total++; if (hash_cnt !== 48'd1) begin bad++; $display("FAIL tight_hash_cnt got=%0d want=1", hash_cnt); end
      total++; if (found_cnt !== 16'd0) begin bad++; $display("FAIL tight_found_cnt got=%0d want=0", found_cnt); end
   endtask

   task automatic test_invalid_target();
      do_reset();
      load_cfg(32'h1d800000);
      total++; if (target_ok !== 1'b0) begin bad++; $display("FAIL inv_target_ok got=%0b want=0", target_ok); end
      in_digest = '0; in_nonce = 32'h5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inv_zero_found got=%0b want=0", out_valid); end
      load_cfg(32'h207fffff);
      total++; if (target_ok !== 1'b1) begin bad++; $display("FAIL max_target_ok got=%0b want=1", target_ok); end
      in_nonce = 32'h6; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL max_zero_found got=%0b want=1", out_valid); end
      total++; if (out_nonce !== 32'h6) begin bad++; $display("FAIL max_zero_nonce got=%h want=6", out_nonce); end
      total++; if (out_hash !== 256'h0) begin bad++; $display("FAIL max_zero_hash got=%h want=0", out_hash); end
   endtask

   task automatic test_overflow();
      do_reset();
      load_cfg(32'h207fffff);
      in_digest = '0;
      for (int n = 1; n <= 6; n++) begin
         in_nonce = 32'(n); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick(); tick();
      total++; if (found_cnt !== 16'd4) begin bad++; $display("FAIL ovf_found_cnt got=%0d want=4", found_cnt); end
      total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL ovf_drop_cnt got=%0d want=2", drop_cnt); end
      total++; if (hash_cnt !== 48'd6) begin bad++; $display("FAIL ovf_hash_cnt got=%0d want=6", hash_cnt); end
      tick();
      total++; if (out_nonce !== 32'd1) begin bad++; $display("FAIL ovf_head_hold got=%0d want=1", out_nonce); end
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_pop_valid%0d got=%0b want=1", k, out_valid); end
         total++; if (out_nonce !== 32'(k)) begin bad++; $display("FAIL ovf_pop_nonce%0d got=%0d want=%0d", k, out_nonce, k); end
         tick();
      end
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%0b want=0", out_valid); end
   endtask

   task automatic test_target_switch();
      do_reset();
      load_cfg(32'h19015f53);
      set_genesis(32'd100); in_valid = 1'b1;
      tick();
      set_genesis(32'd200); cfg_load = 1'b1; cfg_bits = 32'h1700ffff;
      tick();
      in_valid = 1'b0; cfg_load = 1'b0;
      tick(); tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sw_prev_valid got=%0b want=1", out_valid); end
      total++; if (out_nonce !== 32'd100) begin bad++; $display("FAIL sw_prev_nonce got=%0d want=100", out_nonce); end
      total++; if (found_cnt !== 16'd1) begin bad++; $display("FAIL sw_found_cnt got=%0d want=1", found_cnt); end
      total++; if (hash_cnt !== 48'd2) begin bad++; $display("FAIL sw_hash_cnt got=%0d want=2", hash_cnt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sw_second_absent got=%0b want=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      load_cfg(32'h19015f53);
      set_genesis(32'h33087548); in_valid = 1'b1;
      tick();
      in_valid = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (hash_cnt !== 48'd0) begin bad++; $display("FAIL mid_hash_cnt got=%0d want=0", hash_cnt); end
      total++; if (target_ok !== 1'b0) begin bad++; $display("FAIL mid_target_ok got=%0b want=0", target_ok); end
      tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%0b want=0", out_valid); end
      total++; if (found_cnt !== 16'd0) begin bad++; $display("FAIL mid_found_cnt got=%0d want=0", found_cnt); end
      total++; if (out_nonce !== 32'd0) begin bad++; $display("FAIL mid_out_nonce got=%h want=0", out_nonce); end
   endtask

   initial begin
      test_reset();
      test_genesis();
      test_tighter();
      test_invalid_target();
      test_overflow();
      test_target_switch();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bitcoin_share_checker.md
Name: bitcoin_share_checker

Overview:
Downstream stage of the double-SHA256 miner core. It accepts one (digest, nonce) pair per cycle and converts the digest to the Bitcoin hash integer. It compares that integer against the 256-bit target expanded from the compact "bits" field. Winning nonces and their hashes go into a small FIFO, drained over a valid/ready handshake by the host or UART reporter. It also keeps hash and drop counters for throughput monitoring.

Parameters:
FIFO_DEPTH, 4, found-FIFO entries; power of two, 2..16
CNT_W, 48, width of the hashes-checked counter
DROP_W, 16, width of the dropped-share counter

Ports:
clk  in  1  clock (single domain)
rst  in  1  synchronous active-high reset
cfg_load  in  1  strobe: latch cfg_bits and re-expand the target
cfg_bits  in  32  compact target (nBits), e.g. 32'h19015f53
in_valid  in  1  digest/nonce pair valid this cycle; no backpressure
in_digest  in  8x32  SHA256 state words, [0]=H0 .. [7]=H7
in_nonce  in  32  nonce that produced in_digest
out_valid  out  1  found-FIFO non-empty
out_ready  in  1  consumer accepts head entry
out_nonce  out  32  head entry nonce
out_hash  out  256  head entry hash integer (MSB = most significant hash byte)
hash_cnt  out  CNT_W  pairs checked, wraps modulo 2^CNT_W
found_cnt  out  16  shares pushed to the FIFO, saturating at 16'hffff
drop_cnt  out  DROP_W  shares lost to a full FIFO, saturating
target_ok  out  1  current target is valid

Behaviour:
- Reset, applied at any time (mid-pipeline included):
  - Flushes both pipeline stages and empties the FIFO.
  - Zeroes all counters and sets target_q=0, target_ok=0.
  - out_valid=0; out_nonce and out_hash read 0.
  - With target_q=0, nothing matches until the first cfg_load.
- Hash integer: hash = {bswap(d[7]), bswap(d[6]), ..., bswap(d[0])}, where bswap reverses the 4 bytes of a word.
- Target expansion, with E=cfg_bits[31:24] and M=cfg_bits[22:0]:
  - cfg_bits[23]=1 (negative), M=0, or E>32: target_q=0, target_ok=0.
  - E<=3: target = M >> 8*(3-E).
  - Otherwise: target = M << 8*(E-3), truncated to 256 bits; target_ok=1.
  - target_q is registered on the cfg_load edge.
- Pipeline (in_valid=1 at cycle t):
  - Stage 1, edge ending t: register hash, nonce, valid; hash_cnt += 1.
  - Stage 2, edge ending t+1: meet = valid & target_ok & (hash <= target_q), compared as a 256-bit unsigned value. Registered with hash and nonce.
  - Edge ending t+2: if meet, push {nonce, hash}. out_valid first asserts at cycle t+3 when the FIFO was empty. Latency in_valid -> out_valid is 3 cycles.
- Target timing: a sample with in_valid at cycle t is compared against the target loaded by the latest cfg_load at cycle c<=t. cfg_load does not flush in-flight samples.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push when full and no pop in the same cycle: entry discarded, drop_cnt += 1, found_cnt unchanged.
  - Push and pop in the same cycle while full: both succeed, occupancy unchanged.
  - Push and pop in the same cycle while empty with out_valid=0: push only; no bypass.
  - Outputs come from the head register; they hold stable while out_valid & !out_ready.
- found_cnt and drop_cnt saturate; hash_cnt wraps.

Decomposition:
- Package bitcoin_pkg:
  - typedefs: digest_t ([7:0][31:0]) and hash256_t (logic [255:0]).
  - function bswap32 (shared with the existing htonl use).
  - function compact_to_target returning {ok, target}.
  - constant BITS_SIGN_BIT=23.
- Sub-module bitcoin_found_fifo: synchronous FIFO, parameterized depth and width (288 bits), with push/pop/full/empty ports and a registered head.

Test Plan:
- Genesis-style check:
  - Stimulus: cfg_bits=19015f53; in_digest [7..0] = 00000000,00000000,78a467e0,fedd4a02,2836c9cd,2da58a97,42bdfa91,502a9892; nonce=33087548.
  - Response: out_valid at t+3; out_nonce=33087548; out_hash=0000000000000000e067a478024addfecdc93628978aa52d91fabd4292982a50; found_cnt=1.
- Tighter target: same digest with cfg_bits=1700ffff -> no push; hash_cnt=1; found_cnt=0.
- Invalid target: cfg_bits=1d800000 (sign bit set) -> target_ok=0; an all-zero digest is not found. Then cfg_bits=207fffff -> target_ok=1, and the all-zero digest is found.
- FIFO overflow: out_ready=0, 6 consecutive winning pairs, nonces 1..6 -> FIFO holds 1..4; drop_cnt=2. Then out_ready=1 -> pops 1,2,3,4 in order; out_valid drops after the 4th.
- Target switch: cfg_load (cfg_bits=1700ffff) in the same cycle as a 19015f53-winning sample -> sample not found; the sample in the preceding cycle is found.
- Reset mid-run: rst at t+1 after a winning sample -> no push; out_valid=0 and all counters 0 on the following cycle.
